// File: rtl/line_sched_pkg.sv
// Shared types and constants for the line scheduler: FSM encoding, address width
// and error flag bit positions.
package line_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LINE_WAIT = 2'd1,
      S_ISSUE     = 2'd2,
      S_DRAIN     = 2'd3
   } state_t;

   localparam int unsigned ADDR_W = 20;

   localparam int unsigned ERR_FS_BUSY  = 0;
   localparam int unsigned ERR_DONE_UFL = 1;

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down counter used for line credits and in-flight tracking.
// Simultaneous inc/dec leaves the count unchanged; dec at zero is dropped and flagged.
module credit_counter #(
   parameter int unsigned MAX  = 1,
   parameter int unsigned INIT = 0,
   parameter int unsigned W    = $clog2(MAX) + 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_inc,
   input  logic         i_dec,
   output logic [W-1:0] o_count,
   output logic         o_underflow
);

   logic [W-1:0] r_count;
   logic [W-1:0] w_count_nxt;
   logic         w_at_max;
   logic         w_at_zero;
   logic         w_inc_ok;
   logic         w_dec_ok;

   always_comb begin
      w_at_max    = (r_count == W'(MAX));
      w_at_zero   = (r_count == '0);
      // At MAX an inc is only legal when a dec cancels it in the same cycle.
      w_inc_ok    = i_inc && (!w_at_max || i_dec);
      w_dec_ok    = i_dec && !w_at_zero;
      o_underflow = i_dec && w_at_zero;
      w_count_nxt = r_count;
      if (w_inc_ok && !w_dec_ok) begin
         w_count_nxt = r_count + W'(1);
      end else if (w_dec_ok && !w_inc_ok) begin
         w_count_nxt = r_count - W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= W'(INIT);
      end else begin
         r_count <= w_count_nxt;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/line_scheduler.sv
// Raster-order pixel work-item issuer, throttled by downstream line credits and an
// in-flight limit matching the sort window; reports frame completion and errors.
module line_scheduler
   import line_sched_pkg::*;
#(
   parameter int unsigned H_DISP       = 1280,
   parameter int unsigned V_DISP       = 720,
   parameter int unsigned N            = 16,
   parameter int unsigned LINE_CREDITS = 1
) (
   input  logic                     PPL_clk,
   input  logic                     rst_n,
   input  logic                     enable,
   input  logic                     frame_start,
   input  logic                     line_release,
   output logic                     pix_valid,
   input  logic                     pix_ready,
   output logic [ADDR_W-1:0]        pix_addr,
   output logic [$clog2(H_DISP):0]  pix_x,
   output logic [$clog2(V_DISP):0]  pix_y,
   input  logic                     pix_done,
   output logic                     busy,
   output logic                     frame_done,
   output logic [1:0]               err
);

   localparam int unsigned XW = $clog2(H_DISP) + 1;
   localparam int unsigned YW = $clog2(V_DISP) + 1;
   localparam int unsigned IW = $clog2(N) + 1;
   localparam int unsigned CW = $clog2(LINE_CREDITS) + 1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [XW-1:0]       r_x;
   logic [XW-1:0]       w_x_nxt;
   logic [YW-1:0]       r_y;
   logic [YW-1:0]       w_y_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic [1:0]          r_err;
   logic [1:0]          w_err_set;
   logic [IW-1:0]       w_inflight;
   logic [CW-1:0]       w_credit;
   logic                w_credit_take;
   logic                w_credit_ufl_unused;
   logic                w_done_ufl;
   logic                w_xfer;
   logic                w_last_x;
   logic                w_last_y;

   credit_counter #(
      .MAX  (LINE_CREDITS),
      .INIT (LINE_CREDITS),
      .W    (CW)
   ) u_line_credit (
      .i_clk       (PPL_clk),
      .i_rst_n     (rst_n),
      .i_inc       (line_release),
      .i_dec       (w_credit_take),
      .o_count     (w_credit),
      .o_underflow (w_credit_ufl_unused)
   );

   credit_counter #(
      .MAX  (N),
      .INIT (0),
      .W    (IW)
   ) u_inflight (
      .i_clk       (PPL_clk),
      .i_rst_n     (rst_n),
      .i_inc       (w_xfer),
      .i_dec       (pix_done),
      .o_count     (w_inflight),
      .o_underflow (w_done_ufl)
   );

   always_comb begin
      w_last_x      = (r_x == XW'(H_DISP - 1));
      w_last_y      = (r_y == YW'(V_DISP - 1));
      pix_valid     = (r_state == S_ISSUE) && (w_inflight < IW'(N));
      w_xfer        = pix_valid && pix_ready;
      w_credit_take = 1'b0;
      frame_done    = 1'b0;
      w_state_nxt   = r_state;
      w_x_nxt       = r_x;
      w_y_nxt       = r_y;
      w_addr_nxt    = r_addr;
      case (r_state)
         S_IDLE: begin
            if (frame_start && enable) begin
               w_state_nxt = S_LINE_WAIT;
               w_x_nxt     = '0;
               w_y_nxt     = '0;
               w_addr_nxt  = '0;
            end
         end
         S_LINE_WAIT: begin
            if (w_credit != '0) begin
               w_credit_take = 1'b1;
               w_state_nxt   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (w_xfer) begin
               w_addr_nxt = r_addr + ADDR_W'(1);
               if (w_last_x) begin
                  w_x_nxt     = '0;
                  w_y_nxt     = r_y + YW'(1);
                  w_state_nxt = w_last_y ? S_DRAIN : S_LINE_WAIT;
               end else begin
                  w_x_nxt = r_x + XW'(1);
               end
            end
         end
         S_DRAIN: begin
            if (w_inflight == '0) begin
               frame_done  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_err_set               = '0;
      w_err_set[ERR_FS_BUSY]  = frame_start && (r_state != S_IDLE);
      w_err_set[ERR_DONE_UFL] = w_done_ufl;
   end

   always_ff @(posedge PPL_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_x     <= '0;
         r_y     <= '0;
         r_addr  <= '0;
         r_err   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_addr  <= w_addr_nxt;
         r_err   <= r_err | w_err_set;
      end
   end

   assign pix_addr = r_addr;
   assign pix_x    = r_x;
   assign pix_y    = r_y;
   assign busy     = (r_state != S_IDLE);
   assign err      = r_err;

endmodule

// File: tb/tb_line_scheduler.sv
// Scoreboard bench for line_scheduler on an 8x4 frame with an in-flight limit of 4:
// addresses are queued at frame start and popped on every observed transfer.
module tb_line_scheduler;

   localparam int unsigned H    = 8;
   localparam int unsigned V    = 4;
   localparam int unsigned NF   = 4;
   localparam int unsigned LC   = 1;
   localparam int unsigned NPIX = H * V;

   logic        PPL_clk     = 1'b0;
   logic        rst_n       = 1'b0;
   logic        enable      = 1'b0;
   logic        frame_start = 1'b0;
   logic        pix_ready   = 1'b0;
   logic        done_man    = 1'b0;
   logic        rel_man     = 1'b0;
   logic        auto_done   = 1'b0;
   logic        auto_rel    = 1'b0;
   logic [3:0]  done_pipe   = '0;
   logic [5:0]  rel_pipe    = '0;
   logic        pix_done;
   logic        line_release;
   logic        pix_valid;
   logic [19:0] pix_addr;
   logic [3:0]  pix_x;
   logic [2:0]  pix_y;
   logic        busy;
   logic        frame_done;
   logic [1:0]  err;

   int          n_vec  = 0;
   int          n_miss = 0;
   int          n_xfer = 0;
   int          fd_cnt = 0;
   int          exp_q[$];
   logic        hold_vld  = 1'b0;
   logic [19:0] hold_addr = '0;
   logic        mon_xfer;
   int          mon_exp;

   assign pix_done     = done_pipe[3] | done_man;
   assign line_release = rel_pipe[5] | rel_man;

   line_scheduler #(
      .H_DISP       (H),
      .V_DISP       (V),
      .N            (NF),
      .LINE_CREDITS (LC)
   ) dut (
      .PPL_clk      (PPL_clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .frame_start  (frame_start),
      .line_release (line_release),
      .pix_valid    (pix_valid),
      .pix_ready    (pix_ready),
      .pix_addr     (pix_addr),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .pix_done     (pix_done),
      .busy         (busy),
      .frame_done   (frame_done),
      .err          (err)
   );

   always #5 PPL_clk = ~PPL_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Transfer monitor and downstream model: returns pix_done and line_release after fixed delays.
   always @(negedge PPL_clk) begin
      if (!rst_n) begin
         done_pipe = '0;
         rel_pipe  = '0;
         hold_vld  = 1'b0;
      end else begin
         mon_xfer = pix_valid && pix_ready;
         if (hold_vld) begin
            check("hold_valid", 32'(pix_valid), 32'd1);
            check("hold_addr", 32'(pix_addr), 32'(hold_addr));
         end
         hold_vld  = pix_valid && !pix_ready;
         hold_addr = pix_addr;
         if (frame_done === 1'b1) fd_cnt++;
         if (mon_xfer) begin
            n_xfer++;
            if (exp_q.size() == 0) begin
               check("extra_xfer", 32'(pix_addr), 32'hffff_ffff);
            end else begin
               mon_exp = exp_q.pop_front();
               check("addr", 32'(pix_addr), 32'(mon_exp));
               check("x", 32'(pix_x), 32'(mon_exp % H));
               check("y", 32'(pix_y), 32'(mon_exp / H));
            end
         end
         done_pipe = {done_pipe[2:0], mon_xfer && auto_done};
         rel_pipe  = {rel_pipe[4:0], mon_xfer && (pix_x == 4'(H - 1)) && auto_rel};
      end
   end

   task automatic do_reset();
      @(posedge PPL_clk);
      #1;
      rst_n       = 1'b0;
      frame_start = 1'b0;
      done_man    = 1'b0;
      rel_man     = 1'b0;
      repeat (2) @(posedge PPL_clk);
      #1 rst_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic start_frame(input bit check_lat);
      for (int i = 0; i < int'(NPIX); i++) exp_q.push_back(i);
      n_xfer = 0;
      fd_cnt = 0;
      @(posedge PPL_clk);
      #1 frame_start = 1'b1;
      @(posedge PPL_clk);
      #1 frame_start = 1'b0;
      if (check_lat) begin
         @(negedge PPL_clk);
         check("lat_wait_valid", 32'(pix_valid), 32'd0);
         check("lat_busy", 32'(busy), 32'd1);
         @(negedge PPL_clk);
         check("lat_valid", 32'(pix_valid), 32'd1);
         check("lat_addr", 32'(pix_addr), 32'd0);
      end
   endtask

   task automatic wait_frame(input int budget);
      for (int i = 0; i < budget && fd_cnt < 1; i++) begin
         @(posedge PPL_clk);
         #1;
      end
   endtask

   task automatic check_frame(input string tag, input logic [1:0] exp_err);
      repeat (2) @(posedge PPL_clk);
      @(negedge PPL_clk);
      check({tag, "_frame_done"}, 32'(fd_cnt), 32'd1);
      check({tag, "_xfers"}, 32'(n_xfer), 32'(NPIX));
      check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_err"}, 32'(err), 32'(exp_err));
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 32'(pix_valid), 32'd0);
      check({tag, "_addr"}, 32'(pix_addr), 32'd0);
      check({tag, "_x"}, 32'(pix_x), 32'd0);
      check({tag, "_y"}, 32'(pix_y), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_fdone"}, 32'(frame_done), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      // Reset state, then a clean frame with prompt returns.
      do_reset();
      @(negedge PPL_clk);
      check_reset_outputs("rst");
      enable    = 1'b1;
      pix_ready = 1'b1;
      auto_done = 1'b1;
      auto_rel  = 1'b1;
      start_frame(1'b1);
      wait_frame(1000);
      check_frame("basic", 2'b00);

      // In-flight limit: nothing returns, so issue stops at N.
      repeat (5) @(posedge PPL_clk);
      #1 auto_done = 1'b0;
      start_frame(1'b0);
      repeat (20) @(posedge PPL_clk);
      @(negedge PPL_clk);
      check("lim_xfers", 32'(n_xfer), 32'(NF));
      check("lim_valid", 32'(pix_valid), 32'd0);
      check("lim_addr", 32'(pix_addr), 32'(NF));
      @(posedge PPL_clk);
      #1 done_man = 1'b1;
      @(posedge PPL_clk);
      #1 done_man = 1'b0;
      repeat (10) @(posedge PPL_clk);
      @(negedge PPL_clk);
      check("lim_one_more", 32'(n_xfer), 32'(NF + 1));
      check("lim_addr2", 32'(pix_addr), 32'(NF + 1));
      do_reset();

      // Line credit stall after line 0, then one release.
      auto_done = 1'b1;
      auto_rel  = 1'b0;
      start_frame(1'b1);
      repeat (30) @(posedge PPL_clk);
      @(negedge PPL_clk);
      check("stall_xfers", 32'(n_xfer), 32'(H));
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_valid", 32'(pix_valid), 32'd0);
      @(posedge PPL_clk);
      #1;
      rel_man  = 1'b1;
      auto_rel = 1'b1;
      @(posedge PPL_clk);
      #1 rel_man = 1'b0;
      @(negedge PPL_clk);
      check("rel_wait_valid", 32'(pix_valid), 32'd0);
      @(negedge PPL_clk);
      check("rel_valid", 32'(pix_valid), 32'd1);
      check("rel_addr", 32'(pix_addr), 32'(H));
      wait_frame(1000);
      check_frame("stall", 2'b00);

      // Random back-pressure; enable dropped mid-frame must not stop it.
      repeat (10) @(posedge PPL_clk);
      start_frame(1'b0);
      #1 enable = 1'b0;
      for (int i = 0; i < 3000 && fd_cnt < 1; i++) begin
         @(posedge PPL_clk);
         #1 pix_ready = 1'($urandom_range(0, 1));
      end
      pix_ready = 1'b1;
      check_frame("rand", 2'b00);
      // frame_start with enable low in IDLE is not accepted.
      @(posedge PPL_clk);
      #1 frame_start = 1'b1;
      @(posedge PPL_clk);
      #1 frame_start = 1'b0;
      repeat (3) @(posedge PPL_clk);
      @(negedge PPL_clk);
      check("dis_busy", 32'(busy), 32'd0);
      enable = 1'b1;

      // Protocol errors: spurious pix_done with nothing in flight, frame_start while busy.
      repeat (10) @(posedge PPL_clk);
      start_frame(1'b0);
      done_man = 1'b1;
      @(posedge PPL_clk);
      #1 done_man = 1'b0;
      repeat (10) @(posedge PPL_clk);
      #1 frame_start = 1'b1;
      @(posedge PPL_clk);
      #1 frame_start = 1'b0;
      wait_frame(1000);
      check_frame("errs", 2'b11);

      // Asynchronous reset mid-line, then a fresh frame from address 0.
      do_reset();
      @(negedge PPL_clk);
      check("rst2_err", 32'(err), 32'd0);
      start_frame(1'b0);
      for (int i = 0; i < 300; i++) begin
         @(negedge PPL_clk);
         if (pix_valid && pix_addr == 20'd13) break;
      end
      check("pre_rst_addr", 32'(pix_addr), 32'd13);
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      exp_q.delete();
      repeat (2) @(posedge PPL_clk);
      #1 rst_n = 1'b1;
      start_frame(1'b1);
      wait_frame(1000);
      check_frame("restart", 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/line_scheduler.md
Name: line_scheduler

Overview:
- Sequences the render pipeline feeding the pixel sort/align path, all in the PPL_clk domain.
- Starts a frame on a frame-start pulse and issues pixel work items in raster order.
- Throttles issue two ways:
  - line credits, one per free line slot in the downstream line FIFO;
  - an in-flight limit, so the out-of-order window never exceeds the sort depth N.
- Reports frame completion and protocol errors.

Parameters:
- H_DISP, 1280, active pixels per line.
- V_DISP, 720, active lines per frame.
- N, 16, maximum pixels in flight (issued, not yet returned); must match the sort window.
- LINE_CREDITS, 1, line slots available downstream at reset (FIFO depth H_DISP+64 gives 1).

Ports:
- PPL_clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scheduler enable; sampled only in IDLE.
- frame_start  in  1  single-cycle pulse; starts a frame (already synchronised into PPL_clk).
- line_release  in  1  single-cycle pulse; downstream consumed one full line, returns one line credit.
- pix_valid  out  1  work item valid.
- pix_ready  in  1  pipeline accepts the work item.
- pix_addr  out  20  linear address y*H_DISP+x.
- pix_x  out  $clog2(H_DISP)+1  pixel column.
- pix_y  out  $clog2(V_DISP)+1  pixel row.
- pix_done  in  1  pipeline output valid; one pulse per finished pixel.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  single-cycle pulse when the frame is fully drained.
- err  out  2  sticky flags: [0] frame_start while busy, [1] pix_done with nothing in flight.

Behaviour:
- Reset values (async assert, sync release):
  - state IDLE; pix_valid=0, pix_addr=0, pix_x=0, pix_y=0, busy=0, frame_done=0, err=0.
  - line_credit=LINE_CREDITS, inflight=0.
- States:
  - IDLE: frame_start & enable -> LINE_WAIT; x, y and addr are cleared.
  - LINE_WAIT: line_credit>0 -> ISSUE, consuming one credit that cycle.
  - ISSUE:
    - pix_valid = (inflight<N), combinational from registered state.
    - A transfer occurs on pix_valid & pix_ready.
    - On a transfer: x++ and addr++. When x==H_DISP-1: x=0, y++.
    - Next state after the last pixel of a line: y==V_DISP-1 -> DRAIN; otherwise -> LINE_WAIT.
  - DRAIN: inflight==0 -> pulse frame_done for one cycle -> IDLE.
- Address generation is incremental; no multiplier. addr is 20 bits and must hold H_DISP*V_DISP-1.
- Handshake rules:
  - Once pix_valid is asserted, pix_addr/pix_x/pix_y stay stable until the transfer.
  - pix_valid may drop only when inflight reaches N, which cannot happen mid-hold because inflight only rises on a transfer.
- inflight counter (width $clog2(N)+1):
  - +1 on a transfer, -1 on pix_done; both in the same cycle -> unchanged.
  - pix_done with inflight==0 -> ignored, err[1] set.
- line_credit counter:
  - line_release -> +1, saturating at LINE_CREDITS; excess releases are ignored.
  - Consume in LINE_WAIT and release in the same cycle -> unchanged.
- frame_start while busy -> ignored, err[0] set; the current frame continues.
- enable deasserted while busy has no effect until IDLE.
- err clears only on reset.
- Latency:
  - frame_start to first pix_valid = 2 cycles (IDLE->LINE_WAIT->ISSUE) when a credit is available.
  - Last pix_done to frame_done = 1 cycle.

Decomposition:
- Shared package line_sched_pkg holds:
  - state encoding constants S_IDLE, S_LINE_WAIT, S_ISSUE, S_DRAIN;
  - ADDR_W=20;
  - err bit indices ERR_FS_BUSY=0, ERR_DONE_UFL=1.
- Sub-module credit_counter (parameters MAX and INIT; inc/dec inputs, saturating, simultaneous inc/dec nets to zero, underflow flag output), instantiated twice:
  - line credits: INIT=LINE_CREDITS, MAX=LINE_CREDITS;
  - inflight: INIT=0, MAX=N.

Test Plan (H_DISP=8, V_DISP=4, N=4, LINE_CREDITS=1 unless stated):
- pix_ready=1, pix_done returned 3 cycles after each transfer, line_release 5 cycles after each line's last transfer -> 32 transfers, addr 0..31 in order, x wraps 7->0 with y++, one frame_done, err=0.
- pix_ready=1, pix_done withheld -> pix_valid drops after 4 transfers (addr 0..3); one pix_done -> exactly one more transfer (addr 4).
- No line_release after line 0 -> scheduler stalls in LINE_WAIT after addr 7, busy=1; one line_release -> addr 8 issued 2 cycles later.
- pix_ready toggled pseudo-randomly -> pix_addr stable while pix_valid & !pix_ready; no address skipped or duplicated.
- frame_start mid-frame and a spurious pix_done when inflight=0 -> err=2'b11, frame still completes with 32 addresses.
- rst_n asserted mid-line (addr 13) -> all outputs reset immediately; next frame_start restarts at addr 0, line_credit=1.
